imem_fetch_arbiter: RTL and testbench
=====================================

Name: imem_fetch_arbiter

Overview:
Sequences the byte-wide (8-bit cell) instruction memory for the multi-cycle CPU. It assembles one 32-bit big-endian instruction from four consecutive byte reads and returns it on a request/ack handshake. It also shares the same memory port with a byte-serial program loader, using round-robin arbitration. It sits between the CPU's IF stage and the instruction memory array; the array has combinational read and a synchronous write.

Parameters:
MEM_BYTES, 128, instruction memory depth in bytes
ADDR_W, 7, memory byte-address width (log2 MEM_BYTES)

Ports:
CLK  in  1  clock, all state updates on rising edge
Reset  in  1  asynchronous, active-high reset
fetch_req  in  1  CPU requests an instruction; held high until fetch_ack
fetch_addr  in  32  byte address of instruction; sampled at grant
fetch_ack  out  1  one-cycle pulse; fetch_data/fetch_err valid this cycle
fetch_data  out  32  assembled instruction, Mem[a] in [31:24] … Mem[a+3] in [7:0]
fetch_err  out  1  with fetch_ack: misaligned or out-of-range address
load_valid  in  1  loader has a byte to write
load_addr  in  ADDR_W  loader byte address
load_byte  in  8  loader data
load_ready  out  1  loader byte accepted when load_valid && load_ready
busy  out  1  high in any state other than IDLE
mem_addr  out  ADDR_W  memory byte address
mem_we  out  1  memory write enable (write at rising edge)
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory combinational read data

Behaviour:
- Reset state: IDLE.
- Reset values: fetch_ack=0, fetch_data=0, fetch_err=0, busy=0, internal beat counter=0, last_grant=FETCH (so the loader wins the first tie).
- Reset asserted mid-fetch aborts the fetch immediately. No ack is issued. The CPU must re-request.
- States:
  - IDLE: no transfer in progress.
  - FETCH: beat counter cnt runs 0..3.
  - RESP: one cycle; ack presented.
- load_ready = (state==IDLE) && !(fetch_req && last_grant==LOAD). This is combinational.
- Loader write: mem_we = load_valid && load_ready. When mem_we is high, mem_addr=load_addr and mem_wdata=load_byte. A loader transfer sets last_grant=LOAD and stays in IDLE, so each write is single-cycle.
- Fetch grant in IDLE: occurs when fetch_req && (!load_valid || last_grant==LOAD).
  - On grant: latch base=fetch_addr, set last_grant=FETCH, cnt=0.
  - If fetch_addr[1:0]!=0 or fetch_addr > MEM_BYTES-4: go to RESP with err=1, data=0, and no memory access.
  - Otherwise go to FETCH.
- FETCH: mem_addr = base[ADDR_W-1:0] + cnt and mem_we=0. Each edge captures mem_rdata into byte lane (3-cnt) and increments cnt. The edge that captures cnt=3 moves to RESP.
- RESP: fetch_ack=1 for exactly one cycle, with fetch_data and fetch_err held. Next state is IDLE. fetch_data and fetch_err keep their values until the next RESP.
- Latency: grant edge → ack after 5 edges for a valid address (4 FETCH cycles plus RESP). An error ack comes after 1 edge.
- Loader requests during FETCH/RESP are stalled (load_ready=0). A fetch is never preempted.
- Arbitration on a simultaneous fetch_req and load_valid in IDLE: strict alternation.
  - The loader wins if last_grant==FETCH; otherwise the fetch wins.
  - Neither requester can be starved.
- Back-to-back fetches: IDLE is visited for at least one cycle between RESP and the next grant.
- mem_addr wrap: the addition is modulo 2^ADDR_W. The range check guarantees no wrap on valid fetches.
- fetch_req dropping before ack is a protocol violation. The sequence completes and still acks.

Test Plan:
- Load then fetch: loader writes 0x20,0x01,0x00,0x05 to addresses 0..3, then fetch_addr=0. Required: fetch_ack 5 cycles after grant with fetch_data=0x20010005, fetch_err=0, and four loader handshakes with mem_we pulses.
- Misaligned or out-of-range fetch: fetch_addr=0x2 → ack 1 cycle after grant with err=1, data=0, and no mem_addr sweep. fetch_addr=0x7E (MEM_BYTES=128) → ack with err=1.
- Contention alternation: after reset, hold fetch_req and load_valid high together. Required order: loader byte, fetch (5-cycle sweep), loader byte, fetch. load_ready=0 throughout each FETCH/RESP.
- Reset mid-fetch: assert Reset during cnt=2 → state IDLE and all outputs 0 immediately (asynchronous). No fetch_ack follows. A new fetch after release returns correct data.
- Last-word boundary: preload bytes 124..127 = 0xDE,0xAD,0xBE,0xEF and fetch 0x7C → data=0xDEADBEEF, err=0. mem_addr sequence 124,125,126,127.
- Back-to-back fetches of 0 and 4: two acks separated by at least one IDLE cycle, and busy=0 in that cycle.

Source files
------------

// File: rtl/imem_fetch_arbiter.sv
// Byte-serial instruction fetch for the multi-cycle CPU: assembles a big-endian word
// from four byte reads and shares the memory port with the program loader round-robin.
module imem_fetch_arbiter #(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 7
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ack,
  output logic [31:0]       fetch_data,
  output logic              fetch_err,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;
  typedef enum logic {GRANT_FETCH, GRANT_LOAD} grant_t;

  state_t            state, state_nxt;
  grant_t            last_grant;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] base;
  logic [31:0]       asm_q;
  logic              load_go;
  logic              fetch_go;
  logic              addr_bad;

  assign load_ready = (state == IDLE) && !(fetch_req && (last_grant == GRANT_LOAD));
  assign load_go    = load_valid && load_ready;
  assign fetch_go   = (state == IDLE) && fetch_req && (!load_valid || (last_grant == GRANT_LOAD));
  assign addr_bad   = (fetch_addr[1:0] != 2'b00) || (fetch_addr > LAST_WORD);

  assign mem_we    = load_go;
  assign mem_wdata = load_go ? load_byte : 8'h00;
  assign mem_addr  = load_go ? load_addr : base + {{(ADDR_W-2){1'b0}}, cnt};
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fetch_ack = 1'b0;
    case (state)
      IDLE:    if (fetch_go) state_nxt = addr_bad ? RESP : FETCH;
      FETCH:   if (cnt == 2'd3) state_nxt = RESP;
      RESP: begin
        fetch_ack = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bytes land in asm_q lane 3-cnt; the visible result only changes on entry to RESP
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      last_grant <= GRANT_FETCH;
      cnt        <= 2'd0;
      base       <= '0;
      asm_q      <= 32'h0;
      fetch_data <= 32'h0;
      fetch_err  <= 1'b0;
    end else begin
      if (load_go) begin
        last_grant <= GRANT_LOAD;
      end else if (fetch_go) begin
        last_grant <= GRANT_FETCH;
        base       <= fetch_addr[ADDR_W-1:0];
        cnt        <= 2'd0;
        if (addr_bad) begin
          fetch_data <= 32'h0;
          fetch_err  <= 1'b1;
        end
      end
      if (state == FETCH) begin
        asm_q[{~cnt, 3'b000} +: 8] <= mem_rdata;
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          fetch_data <= {asm_q[31:8], mem_rdata};
          fetch_err  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed plus randomized bench for imem_fetch_arbiter with a byte-array memory
// and an independent reference image of what the loader has written.
module tb_imem_fetch_arbiter;

  localparam int MEM_BYTES = 128;
  localparam int ADDR_W    = 7;

  logic              CLK = 1'b0;
  logic              Reset;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_ack;
  logic [31:0]       fetch_data;
  logic              fetch_err;
  logic              load_valid;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_byte;
  logic              load_ready;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic [7:0] ram     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  int n_chk  = 0;
  int n_fail = 0;

  imem_fetch_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .Reset(Reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .fetch_data(fetch_data), .fetch_err(fetch_err),
    .load_valid(load_valid), .load_addr(load_addr), .load_byte(load_byte),
    .load_ready(load_ready), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > 32'(MEM_BYTES - 4));
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [6:0] i;
    i = a[6:0];
    return {ref_mem[i], ref_mem[i + 7'd1], ref_mem[i + 7'd2], ref_mem[i + 7'd3]};
  endfunction

  task automatic do_load(input logic [6:0] a, input logic [7:0] b);
    int n;
    @(negedge CLK);
    load_valid = 1'b1; load_addr = a; load_byte = b;
    #1;
    n = 0;
    while (!load_ready && n < 20) begin
      @(negedge CLK); #1; n++;
    end
    chk1("load_ready", load_ready, 1'b1);
    chk1("load_we", mem_we, 1'b1);
    chk("load_addr", 32'(mem_addr), 32'(a));
    chk("load_wdata", 32'(mem_wdata), 32'(b));
    ref_mem[a] = b;
    @(negedge CLK);
    load_valid = 1'b0;
    #1;
    chk1("load_we_pulse", mem_we, 1'b0);
  endtask

  task automatic do_fetch(input logic [31:0] a);
    int n, n_grant;
    logic [6:0] q[$];
    logic exp_e;
    logic [31:0] exp_d;
    exp_e = is_bad(a);
    exp_d = exp_e ? 32'h0 : word_at(a);
    @(negedge CLK);
    fetch_req = 1'b1; fetch_addr = a;
    #1;
    n = 0; n_grant = -1;
    while (!fetch_ack && n < 20) begin
      @(negedge CLK); #1; n++;
      if (busy && n_grant < 0) n_grant = n;
      if (busy && !fetch_ack) q.push_back(mem_addr);
      if (busy) chk1("ready_low_busy", load_ready, 1'b0);
    end
    chk1("fetch_ack", fetch_ack, 1'b1);
    chk("grant_edge", 32'(n_grant), 32'd1);
    chk("latency", 32'(n - n_grant + 1), exp_e ? 32'd1 : 32'd5);
    chk("fetch_data", fetch_data, exp_d);
    chk1("fetch_err", fetch_err, exp_e);
    chk("sweep_len", 32'(q.size()), exp_e ? 32'd0 : 32'd4);
    for (int k = 0; k < q.size() && k < 4; k++)
      chk("sweep_addr", 32'(q[k]), 32'(a[6:0] + 7'(k)));
    @(negedge CLK);
    fetch_req = 1'b0;
    #1;
    chk1("ack_pulse", fetch_ack, 1'b0);
    chk("data_hold", fetch_data, exp_d);
    chk1("err_hold", fetch_err, exp_e);
  endtask

  initial begin
    int n, cyc;
    logic wrote, saw_ack;
    string seq;
    logic [31:0] a;
    int r;

    Reset = 1'b1; fetch_req = 1'b0; fetch_addr = 32'h0;
    load_valid = 1'b0; load_addr = '0; load_byte = 8'h0;
    repeat (3) @(negedge CLK);
    #1;
    chk1("rst_ack", fetch_ack, 1'b0);
    chk("rst_data", fetch_data, 32'h0);
    chk1("rst_err", fetch_err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", load_ready, 1'b1);
    @(negedge CLK);
    Reset = 1'b0;

    // load then fetch
    do_load(7'd0, 8'h20); do_load(7'd1, 8'h01); do_load(7'd2, 8'h00); do_load(7'd3, 8'h05);
    do_fetch(32'h0);
    chk("load_fetch_word", fetch_data, 32'h20010005);

    // misaligned and out-of-range
    do_fetch(32'h2);
    do_fetch(32'h7E);
    do_fetch(32'h80);
    do_fetch(32'h100);

    // fill the whole memory through the loader
    for (int i = 0; i < MEM_BYTES; i++) do_load(7'(i), 8'($urandom));

    // last-word boundary
    do_load(7'd124, 8'hDE); do_load(7'd125, 8'hAD); do_load(7'd126, 8'hBE); do_load(7'd127, 8'hEF);
    do_fetch(32'h7C);
    chk("last_word", fetch_data, 32'hDEADBEEF);

    // back-to-back fetches of 0 and 4
    @(negedge CLK);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    #1; n = 0;
    while (!fetch_ack && n < 20) begin @(negedge CLK); #1; n++; end
    chk1("b2b_ack0", fetch_ack, 1'b1);
    chk("b2b_data0", fetch_data, word_at(32'h0));
    @(negedge CLK);
    fetch_addr = 32'h4;
    #1;
    chk1("b2b_idle_busy", busy, 1'b0);
    chk1("b2b_idle_ack", fetch_ack, 1'b0);
    n = 0;
    while (!fetch_ack && n < 20) begin @(negedge CLK); #1; n++; end
    chk1("b2b_ack1", fetch_ack, 1'b1);
    chk("b2b_data1", fetch_data, word_at(32'h4));
    @(negedge CLK);
    fetch_req = 1'b0;

    // randomized mix of loads and fetches
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_load(7'($urandom_range(0, MEM_BYTES - 1)), 8'($urandom));
      end else begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      a = $urandom;
        else if (r == 1) a = 32'($urandom_range(0, 140));
        else             a = {28'($urandom_range(0, 31)), 2'b00} & 32'h7C;
        do_fetch(a);
      end
    end

    // asynchronous reset in the middle of a fetch
    @(negedge CLK);
    fetch_req = 1'b1; fetch_addr = 32'h4;
    #1; n = 0;
    while (!(busy && mem_addr == 7'd6) && n < 20) begin @(negedge CLK); #1; n++; end
    chk1("mid_reach_cnt2", busy && mem_addr == 7'd6, 1'b1);
    Reset = 1'b1;
    #1;
    chk1("mid_busy", busy, 1'b0);
    chk1("mid_ack", fetch_ack, 1'b0);
    chk("mid_data", fetch_data, 32'h0);
    chk1("mid_err", fetch_err, 1'b0);
    chk("mid_addr", 32'(mem_addr), 32'h0);
    chk1("mid_we", mem_we, 1'b0);
    fetch_req = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
    saw_ack = 1'b0;
    repeat (8) begin @(negedge CLK); #1; if (fetch_ack) saw_ack = 1'b1; end
    chk1("mid_no_ack", saw_ack, 1'b0);
    do_fetch(32'h4);

    // contention: both requesters held high after reset
    @(negedge CLK); Reset = 1'b1;
    @(negedge CLK); Reset = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    load_valid = 1'b1; load_addr = 7'd16; load_byte = 8'($urandom);
    #1;
    seq = ""; cyc = 0;
    while (seq.len() < 4 && cyc < 60) begin
      wrote = 1'b0;
      if (busy) chk1("cont_ready_busy", load_ready, 1'b0);
      if (mem_we) begin
        seq = {seq, "L"};
        chk("cont_we_addr", 32'(mem_addr), 32'(load_addr));
        ref_mem[load_addr] = load_byte;
        wrote = 1'b1;
      end
      if (fetch_ack) begin
        seq = {seq, "F"};
        chk("cont_data", fetch_data, word_at(32'h0));
        chk1("cont_err", fetch_err, 1'b0);
      end
      @(negedge CLK);
      if (wrote) begin load_addr = load_addr + 7'd1; load_byte = 8'($urandom); end
      #1; cyc++;
    end
    chk1("cont_order", seq == "LFLF", 1'b1);
    fetch_req = 1'b0; load_valid = 1'b0;

    // loader writes made during contention reached memory
    do_fetch(32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
